rv_store: RTL and testbench

RV_STORE -- requirements
Module: rv_store

---
 rtl/rv_store.sv | 193 +++++++++++++++++++
 tb/tb_rv_store.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_store.sv
// rv_store: store unit between the memory stage and a simple request/ack
// write bus. It maps SB/SH/SW onto byte lanes and flags misaligned or
// illegal stores. Storage is one active slot that drives the bus plus one
// queued slot. An active transaction that never sees an ack is abandoned
// after TIMEOUT_CYCLES request cycles.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_flush                 drops the queued (not yet issued) store
//   i_valid/i_funct3/i_addr/i_data   store request; o_ready = slot free
//   o_fault/o_fault_addr    one-cycle pulse for a misaligned/illegal store
//   o_bus_req/o_bus_addr/o_bus_wdata/o_bus_sel, i_bus_ack   write bus
//   o_bus_err               one-cycle pulse when the active store times out
//   o_busy                  any store active or queued
//
// state    | meaning
// IDLE     | no active slot, queue empty
// ACTIVE   | active slot on the bus, queue empty
// ACTIVE_Q | active slot on the bus, queued slot full (o_ready low)
module rv_store #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic        o_fault,
    output logic [31:0] o_fault_addr,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    output logic        o_bus_err,
    output logic        o_busy
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ACTIVE_Q = 2'd2
    } state_t;

    // The timeout fires in the cycle whose no-ack count would reach TIMEOUT_CYCLES.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] act_addr_q, act_addr_d;
    logic [31:0] act_wdata_q, act_wdata_d;
    logic [3:0]  act_sel_q, act_sel_d;
    logic [31:0] que_addr_q, que_addr_d;
    logic [31:0] que_wdata_q, que_wdata_d;
    logic [3:0]  que_sel_q, que_sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [31:0] map_addr, map_wdata;
    logic [3:0]  map_sel;
    logic        bad, accept, take, bus_req, timeout, done;

    always_comb begin
        map_addr  = {i_addr[31:2], 2'b00};
        map_sel   = 4'b0000;
        map_wdata = i_data;
        bad       = 1'b0;
        case (i_funct3)
            3'b000: begin
                map_sel   = 4'b0001 << i_addr[1:0];
                map_wdata = {4{i_data[7:0]}};
            end
            3'b001: begin
                map_sel   = i_addr[1] ? 4'b1100 : 4'b0011;
                map_wdata = {2{i_data[15:0]}};
                bad       = i_addr[0];
            end
            3'b010: begin
                map_sel = 4'b1111;
                bad     = (i_addr[1:0] != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

    assign bus_req = (state_q != IDLE);
    assign o_ready = (state_q != ACTIVE_Q);
    assign accept  = i_valid & o_ready & ~i_flush;
    assign take    = accept & ~bad;
    // An ack in the same cycle wins over the timeout.
    assign timeout = bus_req & ~i_bus_ack & (cnt_q == TO_LAST);
    assign done    = bus_req & (i_bus_ack | timeout);

    always_comb begin
        state_d      = state_q;
        act_addr_d   = act_addr_q;
        act_wdata_d  = act_wdata_q;
        act_sel_d    = act_sel_q;
        que_addr_d   = que_addr_q;
        que_wdata_d  = que_wdata_q;
        que_sel_d    = que_sel_q;
        cnt_d        = cnt_q;
        fault_d      = accept & bad;
        fault_addr_d = (accept & bad) ? i_addr : fault_addr_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (take) begin
                    act_addr_d  = map_addr;
                    act_wdata_d = map_wdata;
                    act_sel_d   = map_sel;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (done) begin
                    cnt_d = 8'd0;
                    if (take) begin
                        act_addr_d  = map_addr;
                        act_wdata_d = map_wdata;
                        act_sel_d   = map_sel;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (take) begin
                        que_addr_d  = map_addr;
                        que_wdata_d = map_wdata;
                        que_sel_d   = map_sel;
                        state_d     = ACTIVE_Q;
                    end
                end
            end
            ACTIVE_Q: begin
                if (done) begin
                    cnt_d = 8'd0;
                    if (i_flush) begin
                        state_d = IDLE;
                    end else begin
                        act_addr_d  = que_addr_q;
                        act_wdata_d = que_wdata_q;
                        act_sel_d   = que_sel_q;
                        state_d     = ACTIVE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (i_flush) begin
                        state_d = ACTIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            act_addr_q   <= 32'd0;
            act_wdata_q  <= 32'd0;
            act_sel_q    <= 4'd0;
            que_addr_q   <= 32'd0;
            que_wdata_q  <= 32'd0;
            que_sel_q    <= 4'd0;
            cnt_q        <= 8'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            act_addr_q   <= act_addr_d;
            act_wdata_q  <= act_wdata_d;
            act_sel_q    <= act_sel_d;
            que_addr_q   <= que_addr_d;
            que_wdata_q  <= que_wdata_d;
            que_sel_q    <= que_sel_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign o_fault      = fault_q;
    assign o_fault_addr = fault_addr_q;
    assign o_bus_req    = bus_req;
    assign o_bus_addr   = act_addr_q;
    assign o_bus_wdata  = act_wdata_q;
    assign o_bus_sel    = act_sel_q;
    assign o_bus_err    = timeout;
    assign o_busy       = bus_req;
endmodule

// File: tb/tb_rv_store.sv
module tb_rv_store;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] data = 32'd0;
    logic        ack = 1'b0;

    logic        o_ready, o_fault, o_bus_req, o_bus_err, o_busy;
    logic [31:0] o_fault_addr, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_sel;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        err;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_fault[$];

    always #5 clk = ~clk;

    rv_store #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_flush      (flush),
        .i_valid      (valid),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_data       (data),
        .o_ready      (o_ready),
        .o_fault      (o_fault),
        .o_fault_addr (o_fault_addr),
        .o_bus_req    (o_bus_req),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_sel    (o_bus_sel),
        .i_bus_ack    (ack),
        .o_bus_err    (o_bus_err),
        .o_busy       (o_busy)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        valid  = 1'b1;
        funct3 = f;
        addr   = a;
        data   = d;
    endtask

    // Monitor: every completed bus transaction and every fault pulse is
    // compared against the oldest expectation pushed by the stimulus.
    always @(negedge clk) begin : mon
        bus_t        e;
        logic [31:0] fa;
        if (o_bus_req && (ack || o_bus_err)) begin
            if (exp_bus.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL bus_unexpected: got addr 0x%08h, no transaction expected", o_bus_addr);
            end else begin
                e = exp_bus.pop_front();
                check32("bus_addr", o_bus_addr, e.addr);
                check32("bus_sel", {28'd0, o_bus_sel}, {28'd0, e.sel});
                check32("bus_wdata", o_bus_wdata, e.wdata);
                check1("bus_err", o_bus_err, e.err);
            end
        end
        if (o_fault) begin
            if (exp_fault.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL fault_unexpected: got fault_addr 0x%08h, no fault expected", o_fault_addr);
            end else begin
                fa = exp_fault.pop_front();
                check32("fault_addr", o_fault_addr, fa);
            end
        end
    end

    initial begin
        logic [31:0] n;

        // reset values, before any clock edge
        #3;
        check1("rst_bus_req", o_bus_req, 1'b0);
        check1("rst_ready", o_ready, 1'b1);
        check1("rst_busy", o_busy, 1'b0);
        check1("rst_fault", o_fault, 1'b0);
        check1("rst_bus_err", o_bus_err, 1'b0);
        check32("rst_bus_addr", o_bus_addr, 32'h0);
        check32("rst_bus_wdata", o_bus_wdata, 32'h0);
        check32("rst_bus_sel", {28'd0, o_bus_sel}, 32'h0);
        check32("rst_fault_addr", o_fault_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // SB 0x1003, accepted on the first edge after reset, ack on 3rd req cycle
        exp_bus.push_back('{32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b0});
        drive(3'b000, 32'h0000_1003, 32'h0000_00A5);
        tick();
        valid = 1'b0;
        n = 32'd0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) ack = 1'b1;
            #1;
            if (o_bus_req) n = n + 32'd1;
            tick();
            ack = 1'b0;
        end
        check32("a_req_cycles", n, 32'd3);
        check1("a_req_low", o_bus_req, 1'b0);
        check1("a_busy_low", o_busy, 1'b0);

        // misaligned SH
        exp_fault.push_back(32'h0000_2001);
        drive(3'b001, 32'h0000_2001, 32'h0000_BEEF);
        tick();
        valid = 1'b0;
        #1;
        check1("b_fault", o_fault, 1'b1);
        check1("b_no_req", o_bus_req, 1'b0);
        check1("b_ready", o_ready, 1'b1);
        tick();
        check1("b_fault_end", o_fault, 1'b0);
        check1("b_no_req_after", o_bus_req, 1'b0);

        // illegal funct3, flush in the fault cycle must not hide the pulse
        exp_fault.push_back(32'h0000_2000);
        drive(3'b011, 32'h0000_2000, 32'h1234_5678);
        tick();
        valid = 1'b0;
        flush = 1'b1;
        #1;
        check1("c_fault", o_fault, 1'b1);
        check1("c_no_req", o_bus_req, 1'b0);
        tick();
        flush = 1'b0;
        check1("c_fault_end", o_fault, 1'b0);

        // SW 0x10 then SW 0x14 back to back, queue fills, ack hands over
        exp_bus.push_back('{32'h0000_0010, 4'b1111, 32'h1111_1111, 1'b0});
        drive(3'b010, 32'h0000_0010, 32'h1111_1111);
        tick();
        #1;
        check1("d_ready_active", o_ready, 1'b1);
        exp_bus.push_back('{32'h0000_0014, 4'b1111, 32'h2222_2222, 1'b0});
        drive(3'b010, 32'h0000_0014, 32'h2222_2222);
        tick();
        valid = 1'b0;
        #1;
        check1("d_ready_full", o_ready, 1'b0);
        check1("d_req", o_bus_req, 1'b1);
        check32("d_addr_first", o_bus_addr, 32'h0000_0010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        check1("d_req_kept", o_bus_req, 1'b1);
        check32("d_addr_second", o_bus_addr, 32'h0000_0014);
        check1("d_ready_again", o_ready, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        check1("d_req_done", o_bus_req, 1'b0);

        // ack and a new acceptance in the same cycle while ACTIVE
        exp_bus.push_back('{32'h0000_3000, 4'b0010, 32'h5A5A_5A5A, 1'b0});
        drive(3'b000, 32'h0000_3001, 32'h0000_005A);
        tick();
        exp_bus.push_back('{32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 1'b0});
        drive(3'b001, 32'h0000_3002, 32'h1234_BEEF);
        ack = 1'b1;
        tick();
        valid = 1'b0;
        ack = 1'b0;
        #1;
        check1("e_req_kept", o_bus_req, 1'b1);
        check32("e_sel", {28'd0, o_bus_sel}, 32'h0000_000C);
        check32("e_wdata", o_bus_wdata, 32'hBEEF_BEEF);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        check1("e_req_done", o_bus_req, 1'b0);

        // queued store flushed; active store still completes
        exp_bus.push_back('{32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 1'b0});
        drive(3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        tick();
        drive(3'b010, 32'h0000_0044, 32'h1234_5678);
        tick();
        valid = 1'b0;
        #1;
        check1("f_ready_full", o_ready, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check1("f_ready_after_flush", o_ready, 1'b1);
        check1("f_req", o_bus_req, 1'b1);
        check32("f_addr", o_bus_addr, 32'h0000_0040);
        check1("f_busy", o_busy, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        check1("f_req_done", o_bus_req, 1'b0);
        check1("f_busy_done", o_busy, 1'b0);

        // flush and ack together in ACTIVE_Q
        exp_bus.push_back('{32'h0000_0050, 4'b1111, 32'h5555_5555, 1'b0});
        drive(3'b010, 32'h0000_0050, 32'h5555_5555);
        tick();
        drive(3'b010, 32'h0000_0054, 32'h6666_6666);
        tick();
        valid = 1'b0;
        flush = 1'b1;
        ack = 1'b1;
        tick();
        flush = 1'b0;
        ack = 1'b0;
        #1;
        check1("g_req", o_bus_req, 1'b0);
        check1("g_busy", o_busy, 1'b0);
        check1("g_ready", o_ready, 1'b1);
        tick();
        check1("g_req_later", o_bus_req, 1'b0);

        // timeout: err in the 4th no-ack request cycle, req drops next
        exp_bus.push_back('{32'h0000_0060, 4'b0001, 32'h7777_7777, 1'b1});
        drive(3'b000, 32'h0000_0060, 32'h0000_0077);
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check1("h_err", o_bus_err, c == 4);
            check1("h_req", o_bus_req, 1'b1);
            tick();
        end
        check1("h_req_dropped", o_bus_req, 1'b0);
        check1("h_err_end", o_bus_err, 1'b0);
        check1("h_busy", o_busy, 1'b0);

        // ack in the timeout cycle wins
        exp_bus.push_back('{32'h0000_0070, 4'b1100, 32'hABCD_ABCD, 1'b0});
        drive(3'b001, 32'h0000_0072, 32'h0000_ABCD);
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check1("i_err_early", o_bus_err, 1'b0);
            tick();
        end
        ack = 1'b1;
        #1;
        check1("i_err_ack_wins", o_bus_err, 1'b0);
        tick();
        ack = 1'b0;
        check1("i_req_done", o_bus_req, 1'b0);

        // reset during an active request
        drive(3'b010, 32'h0000_0080, 32'h8888_8888);
        tick();
        valid = 1'b0;
        #1;
        check1("j_req", o_bus_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check1("j_req_reset", o_bus_req, 1'b0);
        check1("j_err_reset", o_bus_err, 1'b0);
        check1("j_ready_reset", o_ready, 1'b1);
        check1("j_busy_reset", o_busy, 1'b0);
        check32("j_addr_reset", o_bus_addr, 32'h0);
        check32("j_sel_reset", {28'd0, o_bus_sel}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check1("j_req_after", o_bus_req, 1'b0);

        check32("bus_queue_left", exp_bus.size(), 32'd0);
        check32("fault_queue_left", exp_fault.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
